la_readout_serializer: RTL and testbench
========================================

LA_READOUT_SERIALIZER -- requirements
Module: la_readout_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 128, capture sample width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 9, capture depth = 2**ADDR_WIDTH samples.
REQ-003 Parameter READ_LATENCY, default 1, clocks from la_read_addr change to valid la_read_data.
REQ-004 Parameter SYNC_BYTE, default 8'hA5, frame header byte.
REQ-005 clk  input  1  sole clock; all logic on posedge clk.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle dump request from host.
REQ-008 la_done  input  1  analyzer capture-complete flag.
REQ-009 la_read_addr  output  ADDR_WIDTH  sample offset presented to analyzer.
REQ-010 la_read_data  input  DATA_WIDTH  sample returned by analyzer.
REQ-011 la_rearm  output  1  one-cycle pulse to analyzer reset input.
REQ-012 tx_data  output  8  byte to transmitter.
REQ-013 tx_valid  output  1  tx_data valid.
REQ-014 tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, WAIT_DONE, HEADER, FETCH, WAIT_DATA, SEND, REARM.
REQ-017 IDLE: start -> WAIT_DONE; start in any other state SHALL be ignored.
REQ-018 WAIT_DONE: la_done high -> HEADER with la_read_addr=0; otherwise hold indefinitely.
REQ-019 HEADER: tx_data=SYNC_BYTE, tx_valid=1; on handshake -> FETCH.
REQ-020 FETCH: la_read_addr stable; -> WAIT_DATA, which counts READ_LATENCY cycles then latches la_read_data into shift register and -> SEND.
REQ-021 SEND: emits DATA_WIDTH/8 bytes, most-significant byte first; tx_data/tx_valid SHALL stay constant while tx_valid && !tx_ready.
REQ-022 Byte counter advances only on handshake; after last byte: if la_read_addr == 2**ADDR_WIDTH-1 -> REARM, else la_read_addr+1 and -> FETCH.
REQ-023 la_read_addr increment SHALL be ADDR_WIDTH-bit modular; no wrap occurs within one frame.
REQ-024 REARM: la_rearm=1 for exactly one cycle, then IDLE.
REQ-025 Frame length SHALL be 1 + 2**ADDR_WIDTH * DATA_WIDTH/8 bytes (8193 at defaults).
REQ-026 la_done falling in HEADER/FETCH/WAIT_DATA/SEND SHALL abort to IDLE next cycle: tx_valid dropped, no la_rearm pulse.
REQ-027 tx_valid SHALL be 0 in IDLE, WAIT_DONE, FETCH, WAIT_DATA, REARM.
REQ-028 Throughput: at most one byte per clock in SEND; READ_LATENCY+1 idle cycles between samples permitted.

Reset
REQ-029 reset SHALL asynchronously force state=IDLE, la_read_addr=0, tx_data=0, tx_valid=0, la_rearm=0, busy=0, byte counter and shift register=0.
REQ-030 reset asserted mid-frame SHALL abandon the frame; no la_rearm pulse issued.

Structure
REQ-031 Shared package SHALL hold the state encoding constants and SYNC_BYTE default.
REQ-032 Block SHALL be a single module; the byte shift register/counter MAY be one sub-module, la_word_shifter.

Verification
REQ-033 Analyzer model with sample n = {16{n[7:0]}}, tx_ready=1, start with la_done=1 -> 8193 bytes: A5, then 16×00, 16×01, ..., 16×FF, 16×00 ...; single la_rearm pulse after final byte.
REQ-034 start with la_done=0 for 50 cycles, then la_done=1 -> no tx_valid before la_done; frame then identical to REQ-033.
REQ-035 tx_ready random 30% duty -> same byte sequence; tx_data unchanged across every stalled cycle.
REQ-036 la_done dropped after 100 bytes -> tx_valid low next cycle, state IDLE, la_rearm never asserted.
REQ-037 reset asserted during SEND at sample 7 -> all outputs 0 immediately (asynchronous); new start yields full frame from sample 0.
REQ-038 READ_LATENCY=2 build, sample n word = n zero-extended -> byte 16 of each sample equals n[7:0], no stale data.

Source files
------------

// File: rtl/la_readout_serializer_pkg.sv
// Shared definitions for the logic-analyzer readout serializer: FSM state
// encoding and the default frame sync byte.
package la_readout_serializer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DONE = 3'd1,
    S_HEADER    = 3'd2,
    S_FETCH     = 3'd3,
    S_WAIT_DATA = 3'd4,
    S_SEND      = 3'd5,
    S_REARM     = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/la_word_shifter.sv
// Holds one captured sample and hands it out a byte at a time, most
// significant byte first. `last` flags the final byte of the sample.
module la_word_shifter #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [7:0]            byte_out,
  output logic                  last
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_WIDTH-1:0] sr;
  logic [CW-1:0]         cnt;

  // Load a fresh sample, or move the next byte into the top position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data_in;
      cnt <= '0;
    end else if (shift) begin
      sr  <= sr << 8;
      cnt <= cnt + CW'(1);
    end
  end

  assign byte_out = sr[DATA_WIDTH-1 -: 8];
  assign last     = (cnt == CW'(NBYTES - 1));

endmodule

// File: rtl/la_readout_serializer.sv
// Dumps a completed logic-analyzer capture as a byte stream: one sync byte,
// then every sample MSB-first, then a one-cycle rearm pulse to the analyzer.
//
// Byte handshake: a byte transfers on a rising clk edge where
// tx_valid && tx_ready; while tx_valid && !tx_ready, tx_valid and tx_data
// hold their values. tx_valid is high only in HEADER and SEND.
// Dropping la_done mid-frame aborts to IDLE without a rearm pulse.
module la_readout_serializer
  import la_readout_serializer_pkg::*;
#(
  parameter int         DATA_WIDTH   = 128,
  parameter int         ADDR_WIDTH   = 9,
  parameter int         READ_LATENCY = 1,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  la_done,
  output logic [ADDR_WIDTH-1:0] la_read_addr,
  input  logic [DATA_WIDTH-1:0] la_read_data,
  output logic                  la_rearm,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int                  LCW       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  state_t          state_q, state_d;
  logic [LCW-1:0]  lat_cnt;
  logic            lat_last;
  logic            load, shift, next_sample;
  logic [7:0]      byte_out;
  logic            byte_last;

  assign lat_last = (lat_cnt == LCW'(READ_LATENCY - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; la_done low aborts any transfer state.
  always_comb begin
    state_d     = state_q;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    la_rearm    = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    next_sample = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (la_done) state_d = S_HEADER;
      end
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (!la_done)      state_d = S_IDLE;
        else if (tx_ready) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!la_done) state_d = S_IDLE;
        else          state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (!la_done) state_d = S_IDLE;
        else if (lat_last) begin
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = byte_out;
        shift    = tx_ready;
        if (!la_done) state_d = S_IDLE;
        else if (tx_ready && byte_last) begin
          if (la_read_addr == ADDR_LAST) state_d = S_REARM;
          else begin
            next_sample = 1'b1;
            state_d     = S_FETCH;
          end
        end
      end
      S_REARM: begin
        la_rearm = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sample address: cleared at frame start, stepped after each full sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 la_read_addr <= '0;
    else if (state_q == S_WAIT_DONE && la_done) la_read_addr <= '0;
    else if (next_sample)                      la_read_addr <= la_read_addr + ADDR_WIDTH'(1);
  end

  // Counts read-latency cycles spent waiting for the analyzer's data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      lat_cnt <= '0;
    else if (state_q == S_WAIT_DATA) lat_cnt <= lat_cnt + LCW'(1);
    else                            lat_cnt <= '0;
  end

  la_word_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .data_in  (la_read_data),
    .byte_out (byte_out),
    .last     (byte_last)
  );

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_la_readout_serializer.sv
module tb_la_readout_serializer;
  import la_readout_serializer_pkg::*;

  localparam int DW     = 128;
  localparam int AW     = 9;
  localparam int NB     = DW / 8;
  localparam int DEPTH  = 1 << AW;
  localparam int FRAME  = 1 + DEPTH * NB;
  localparam int AW2    = 3;
  localparam int DEPTH2 = 1 << AW2;
  localparam int FRAME2 = 1 + DEPTH2 * NB;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, la_done = 1'b0, tx_ready = 1'b1;
  logic [AW-1:0] la_read_addr;
  logic [DW-1:0] la_read_data;
  logic la_rearm, tx_valid, busy;
  logic [7:0] tx_data;
  logic [2:0] dbg_state;

  logic start2 = 1'b0, la_done2 = 1'b1, tx_ready2 = 1'b1;
  logic [AW2-1:0] la_read_addr2;
  logic [DW-1:0] la_read_data2;
  logic la_rearm2, tx_valid2, busy2;
  logic [7:0] tx_data2;
  logic [2:0] dbg_state2;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;
  int rearm_cnt = 0;
  int rearm2_cnt = 0;
  int hs_cnt = 0;
  bit record = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_rearm = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got2_q[$];

  la_readout_serializer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(rst), .start(start), .la_done(la_done),
    .la_read_addr(la_read_addr), .la_read_data(la_read_data), .la_rearm(la_rearm),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .dbg_state(dbg_state)
  );

  la_readout_serializer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW2), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(rst), .start(start2), .la_done(la_done2),
    .la_read_addr(la_read_addr2), .la_read_data(la_read_data2), .la_rearm(la_rearm2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2),
    .dbg_state(dbg_state2)
  );

  // ---------------- analyzer models ----------------
  function automatic logic [DW-1:0] sample_word(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {NB{b}};
  endfunction

  logic [DW-1:0] rd1 = '0;
  logic [DW-1:0] rd2a = '0, rd2b = '0;
  always @(posedge clk) begin
    rd1  <= sample_word(int'(la_read_addr));
    rd2a <= DW'(la_read_addr2);
    rd2b <= rd2a;
  end
  assign la_read_data  = rd1;
  assign la_read_data2 = rd2b;

  // ---------------- checking helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected byte stream for one full frame, built from the frame rules.
  function automatic void build_frame();
    logic [DW-1:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int n = 0; n < DEPTH; n++) begin
      w = sample_word(n);
      for (int b = 0; b < NB; b++) exp_q.push_back(w[DW-1-8*b -: 8]);
    end
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && la_done) begin
        check("stall_hold_valid", 32'(tx_valid), 32'd1);
        check("stall_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (dbg_state != S_HEADER && dbg_state != S_SEND)
        check("valid_low_in_state", 32'(tx_valid), 32'd0);
      check("busy_vs_state", 32'(busy), 32'(dbg_state != S_IDLE));
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        if (record) got_q.push_back(tx_data);
      end
      if (la_rearm) begin
        rearm_cnt++;
        check("rearm_after_last", 32'(exp_q.size()), 32'd0);
        check("rearm_one_cycle", 32'(prev_rearm), 32'd0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_rearm = la_rearm;
      if (tx_valid2) got2_q.push_back(tx_data2);
      if (la_rearm2) rearm2_cnt++;
    end else begin
      prev_stall = 1'b0;
      prev_rearm = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = (ready_mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_rearm(input int budget, input string name);
    int r0;
    int n;
    r0 = rearm_cnt;
    n = 0;
    while (rearm_cnt == r0 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(rearm_cnt - r0), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    int h0;
    int n;
    logic [7:0] e2[$];

    #1 rst = 1'b1;
    #20;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_la_rearm", 32'(la_rearm), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(la_read_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    // Full frame, done already high, ready always high; a stray start mid-frame is ignored.
    la_done = 1'b1;
    build_frame();
    got_q.delete();
    record = 1'b1;
    r0 = rearm_cnt;
    pulse_start();
    tick(300);
    pulse_start();
    wait_rearm(12000, "frame1_rearm");
    record = 1'b0;
    check("frame1_idle_after", 32'(dbg_state), 32'(S_IDLE));
    check("frame1_busy_after", 32'(busy), 32'd0);
    tick(5);
    check("frame1_single_rearm", 32'(rearm_cnt - r0), 32'd1);
    check("frame1_len", 32'(got_q.size()), 32'(FRAME));
    if (got_q.size() == FRAME) begin
      check("lit_byte0", 32'(got_q[0]), 32'hA5);
      check("lit_byte1", 32'(got_q[1]), 32'h00);
      check("lit_byte16", 32'(got_q[16]), 32'h00);
      check("lit_byte17", 32'(got_q[17]), 32'h01);
      check("lit_byte4096", 32'(got_q[4096]), 32'hFF);
      check("lit_byte4097", 32'(got_q[4097]), 32'h00);
      check("lit_byte8192", 32'(got_q[8192]), 32'hFF);
    end

    // Start while capture not done: nothing sent for 50 cycles, then full frame.
    la_done = 1'b0;
    build_frame();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      check("wait_done_no_valid", 32'(tx_valid), 32'd0);
      check("wait_done_state", 32'(dbg_state), 32'(S_WAIT_DONE));
      tick(1);
    end
    la_done = 1'b1;
    wait_rearm(12000, "frame2_rearm");

    // Random 30% ready duty: same byte stream, data held while stalled.
    build_frame();
    ready_mode = 1;
    pulse_start();
    wait_rearm(45000, "frame3_rearm");
    ready_mode = 0;
    tick(3);

    // la_done dropped after 100 bytes: abort without rearm.
    build_frame();
    r0 = rearm_cnt;
    pulse_start();
    h0 = hs_cnt;
    n = 0;
    while (hs_cnt - h0 < 100 && n < 500) begin
      tick(1);
      n++;
    end
    check("abort_reached_100", 32'(hs_cnt - h0 >= 100), 32'd1);
    la_done = 1'b0;
    tick(1);
    check("abort_valid_low", 32'(tx_valid), 32'd0);
    check("abort_state_idle", 32'(dbg_state), 32'(S_IDLE));
    exp_q.delete();
    tick(20);
    check("abort_no_rearm", 32'(rearm_cnt - r0), 32'd0);
    check("abort_busy_low", 32'(busy), 32'd0);

    // Asynchronous reset during SEND of sample 7, then a clean full frame.
    la_done = 1'b1;
    build_frame();
    pulse_start();
    n = 0;
    while (!(tx_valid && la_read_addr == AW'(7)) && n < 500) begin
      tick(1);
      n++;
    end
    check("reach_sample7", 32'(tx_valid && la_read_addr == AW'(7)), 32'd1);
    tick(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'd0);
    check("async_rst_data", 32'(tx_data), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_addr", 32'(la_read_addr), 32'd0);
    check("async_rst_rearm", 32'(la_rearm), 32'd0);
    exp_q.delete();
    r0 = rearm_cnt;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("rst_no_rearm", 32'(rearm_cnt - r0), 32'd0);
    build_frame();
    pulse_start();
    wait_rearm(12000, "frame5_rearm");
    check("frame5_rearm_count", 32'(rearm_cnt - r0), 32'd1);

    // READ_LATENCY=2 instance: last byte of sample n must be n, others zero.
    got2_q.delete();
    e2.push_back(8'hA5);
    for (int s = 0; s < DEPTH2; s++)
      for (int b = 0; b < NB; b++) e2.push_back((b == NB - 1) ? 8'(s) : 8'h00);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    n = 0;
    while (rearm2_cnt == 0 && n < 2000) begin
      tick(1);
      n++;
    end
    check("rl2_rearm", 32'(rearm2_cnt), 32'd1);
    check("rl2_len", 32'(got2_q.size()), 32'(FRAME2));
    for (int i = 0; i < FRAME2 && i < got2_q.size(); i++)
      check("rl2_byte", 32'(got2_q[i]), 32'(e2[i]));

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
